// File: rtl/ddr_rw_arbiter_if.sv
// User-side request/response signals and the MIG app-side bus of the DDR
// read/write arbiter. The arbiter uses the master view; the requester/MIG side uses the slave view.
interface ddr_rw_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128
);
  logic              init_calib_complete;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              busy_write;
  logic              busy_read;

  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    input  init_calib_complete,
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output wr_ack, rd_ack, rd_data, rd_valid,
    output busy_write, busy_read,
    output app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output init_calib_complete,
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  wr_ack, rd_ack, rd_data, rd_valid,
    input  busy_write, busy_read,
    input  app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// Arbitrates single-word write and read requests onto a MIG app interface,
// bounding read bursts while a write waits and limiting outstanding reads.
module ddr_rw_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 128,
  parameter int MAX_RD_RUN = 8,
  parameter int MAX_RD_OUT = 4
) (
  input  logic           clk,
  input  logic           cpu_resetn,
  ddr_rw_arbiter_if.master bus
);

  localparam int OUT_W = $clog2(MAX_RD_OUT + 1);
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cmd_done;
  logic              r_data_done;
  logic [OUT_W-1:0]  r_outstanding;
  logic [OUT_W-1:0]  w_outstanding_nxt;
  logic [RUN_W-1:0]  r_rd_run;
  logic [RUN_W-1:0]  w_rd_run_nxt;

  logic              r_app_en;
  logic [2:0]        r_app_cmd;
  logic [ADDR_W-1:0] r_app_addr;
  logic [DATA_W-1:0] r_app_wdf_data;
  logic              r_app_wdf_wren;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_busy_write;
  logic              r_busy_read;

  logic              w_idle;
  logic              w_rd_allowed;
  logic              w_rd_grant;
  logic              w_wr_grant;
  logic              w_cmd_acc;
  logic              w_data_acc;
  logic              w_rd_acc;
  logic              w_cmd_done_nxt;
  logic              w_data_done_nxt;

  logic              w_app_en_nxt;
  logic [2:0]        w_app_cmd_nxt;
  logic              w_wren_nxt;
  logic              w_busy_write_nxt;
  logic              w_busy_read_nxt;

  // Reads win unless the outstanding window is full or a waiting write has
  // already watched MAX_RD_RUN reads go ahead of it.
  assign w_idle       = (r_state == S_IDLE);
  assign w_rd_allowed = bus.rd_req
                        && (r_outstanding < OUT_W'(MAX_RD_OUT))
                        && !(bus.wr_req && (r_rd_run >= RUN_W'(MAX_RD_RUN)));
  assign w_rd_grant   = w_idle && bus.init_calib_complete && w_rd_allowed;
  assign w_wr_grant   = w_idle && bus.init_calib_complete && !w_rd_allowed && bus.wr_req;

  assign w_cmd_acc       = r_app_en && bus.app_rdy;
  assign w_data_acc      = r_app_wdf_wren && bus.app_wdf_rdy;
  assign w_rd_acc        = (r_state == S_RD) && w_cmd_acc;
  assign w_cmd_done_nxt  = (r_state == S_WR) && (r_cmd_done || w_cmd_acc);
  assign w_data_done_nxt = (r_state == S_WR) && (r_data_done || w_data_acc);

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_state       <= S_IDLE;
      r_cmd_done    <= 1'b0;
      r_data_done   <= 1'b0;
      r_outstanding <= '0;
      r_rd_run      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_done    <= w_cmd_done_nxt && (w_state_nxt == S_WR);
      r_data_done   <= w_data_done_nxt && (w_state_nxt == S_WR);
      r_outstanding <= w_outstanding_nxt;
      r_rd_run      <= w_rd_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_rd_grant)      w_state_nxt = S_RD;
        else if (w_wr_grant) w_state_nxt = S_WR;
      end
      S_WR: begin
        if (w_cmd_done_nxt && w_data_done_nxt) w_state_nxt = S_IDLE;
      end
      S_RD: begin
        if (w_cmd_acc) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that the registered versions
  // line up with the state they belong to.
  always_comb begin
    w_app_en_nxt     = 1'b0;
    w_app_cmd_nxt    = CMD_WR;
    w_wren_nxt       = 1'b0;
    w_busy_write_nxt = 1'b0;
    unique case (w_state_nxt)
      S_WR: begin
        w_app_en_nxt     = !w_cmd_done_nxt;
        w_wren_nxt       = !w_data_done_nxt;
        w_busy_write_nxt = 1'b1;
      end
      S_RD: begin
        w_app_en_nxt  = 1'b1;
        w_app_cmd_nxt = CMD_RD;
      end
      default: begin
        w_app_en_nxt = 1'b0;
      end
    endcase
    w_busy_read_nxt = (w_state_nxt == S_RD) || (w_outstanding_nxt != '0);
  end

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_rd_acc && !bus.app_rd_data_valid) begin
      if (r_outstanding < OUT_W'(MAX_RD_OUT)) w_outstanding_nxt = r_outstanding + OUT_W'(1);
    end else if (!w_rd_acc && bus.app_rd_data_valid) begin
      if (r_outstanding != '0) w_outstanding_nxt = r_outstanding - OUT_W'(1);
    end
  end

  always_comb begin
    w_rd_run_nxt = r_rd_run;
    if (w_wr_grant || !bus.wr_req) begin
      w_rd_run_nxt = '0;
    end else if (w_rd_grant && (r_rd_run < RUN_W'(MAX_RD_RUN))) begin
      w_rd_run_nxt = r_rd_run + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_app_en       <= 1'b0;
      r_app_cmd      <= CMD_WR;
      r_app_addr     <= '0;
      r_app_wdf_data <= '0;
      r_app_wdf_wren <= 1'b0;
      r_wr_ack       <= 1'b0;
      r_rd_ack       <= 1'b0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_busy_write   <= 1'b0;
      r_busy_read    <= 1'b0;
    end else begin
      r_app_en       <= w_app_en_nxt;
      r_app_cmd      <= w_app_cmd_nxt;
      r_app_wdf_wren <= w_wren_nxt;
      r_wr_ack       <= w_wr_grant;
      r_rd_ack       <= w_rd_grant;
      r_rd_data      <= bus.app_rd_data;
      r_rd_valid     <= bus.app_rd_data_valid;
      r_busy_write   <= w_busy_write_nxt;
      r_busy_read    <= w_busy_read_nxt;
      if (w_rd_grant) begin
        r_app_addr <= bus.rd_addr;
      end else if (w_wr_grant) begin
        r_app_addr     <= bus.wr_addr;
        r_app_wdf_data <= bus.wr_data;
      end
    end
  end

  assign bus.app_en       = r_app_en;
  assign bus.app_cmd      = r_app_cmd;
  assign bus.app_addr     = r_app_addr;
  assign bus.app_wdf_data = r_app_wdf_data;
  assign bus.app_wdf_wren = r_app_wdf_wren;
  assign bus.app_wdf_end  = r_app_wdf_wren;
  assign bus.wr_ack       = r_wr_ack;
  assign bus.rd_ack       = r_rd_ack;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.busy_write   = r_busy_write;
  assign bus.busy_read    = r_busy_read;

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Self-checking bench for ddr_rw_arbiter: requester and MIG models with
// scoreboards for commands and returned read data.
`timescale 1ns/1ps
module tb_ddr_rw_arbiter;
  localparam int ADDR_W     = 27;
  localparam int DATA_W     = 128;
  localparam int MAX_RD_RUN = 8;
  localparam int MAX_RD_OUT = 4;
  localparam int UNLIM      = 32'h3fff_ffff;
  localparam logic [DATA_W-1:0] PATTERN = 128'h0123456789ABCDEF0123456789ABCDEF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic cpu_resetn = 1'b0;
  always #5 clk = ~clk;

  ddr_rw_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr_rw_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD_RUN(MAX_RD_RUN), .MAX_RD_OUT(MAX_RD_OUT)
  ) dut (
    .clk(clk),
    .cpu_resetn(cpu_resetn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  req_t wr_q[$];
  req_t rd_q[$];
  logic [DATA_W-1:0] exp_q[$];
  bit cmd_log[$];
  int acc_rd = 0;
  int resp_done = 0;
  int resp_allow = 0;
  bit resp_fixed = 1'b0;
  bit wr_auto = 1'b0;
  bit rd_auto = 1'b0;
  logic prev_vld = 1'b0;
  logic [ADDR_W-1:0] next_addr = 27'h100;

  task automatic issue_write();
    req_t r;
    r.addr = next_addr;
    r.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    next_addr = next_addr + 27'h8;
    bus.wr_req = 1'b1; bus.wr_addr = r.addr; bus.wr_data = r.data;
    wr_q.push_back(r);
  endtask

  task automatic issue_read();
    req_t r;
    r.addr = next_addr;
    r.data = '0;
    next_addr = next_addr + 27'h8;
    bus.rd_req = 1'b1; bus.rd_addr = r.addr;
    rd_q.push_back(r);
  endtask

  // Scoreboard side: runs on the falling edge, where the cycle's values are stable.
  task automatic monitor();
    req_t c;
    if (cpu_resetn && bus.app_en && bus.app_rdy) begin
      checks++;
      if (bus.app_cmd == 3'b001) begin
        acc_rd++;
        cmd_log.push_back(1'b1);
        if (rd_q.size() == 0) begin
          errors++; $display("FAIL sb_read_cmd got addr %h want no command", bus.app_addr);
        end else begin
          c = rd_q.pop_front();
          if (bus.app_addr !== c.addr) begin
            errors++; $display("FAIL sb_read_addr got %h want %h", bus.app_addr, c.addr);
          end
        end
      end else begin
        cmd_log.push_back(1'b0);
        if (wr_q.size() == 0) begin
          errors++; $display("FAIL sb_write_cmd got cmd %b addr %h want no command", bus.app_cmd, bus.app_addr);
        end else begin
          c = wr_q.pop_front();
          if (bus.app_cmd !== 3'b000 || bus.app_addr !== c.addr || bus.app_wdf_data !== c.data) begin
            errors++;
            $display("FAIL sb_write_cmd got cmd %b addr %h data %h want cmd 000 addr %h data %h",
                     bus.app_cmd, bus.app_addr, bus.app_wdf_data, c.addr, c.data);
          end
        end
      end
    end
    if (bus.rd_valid || prev_vld) begin
      checks++;
      if (bus.rd_valid !== prev_vld) begin
        errors++; $display("FAIL rd_valid_latency got %b want %b", bus.rd_valid, prev_vld);
      end
    end
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_rd_data got %h want no word", bus.rd_data);
      end else if (bus.rd_data !== exp_q[0]) begin
        errors++; $display("FAIL sb_rd_data got %h want %h", bus.rd_data, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
    prev_vld = bus.app_rd_data_valid;
  endtask

  task automatic respond();
    logic [DATA_W-1:0] d;
    if (resp_done < acc_rd && resp_done < resp_allow) begin
      d = resp_fixed ? PATTERN : {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data = d;
      exp_q.push_back(d);
      resp_done++;
    end else begin
      bus.app_rd_data_valid = 1'b0;
    end
  endtask

  task automatic requester();
    if (bus.wr_ack === 1'b1) begin
      if (wr_auto) issue_write(); else bus.wr_req = 1'b0;
    end
    if (bus.rd_ack === 1'b1) begin
      if (rd_auto) issue_read(); else bus.rd_req = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    respond();
    requester();
  endtask

  task automatic test_reset();
    cpu_resetn = 1'b0;
    bus.init_calib_complete = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data = PATTERN; bus.app_rd_data_valid = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wr_ack, bus.rd_ack,
         bus.rd_valid, bus.busy_write, bus.busy_read} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000", {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end,
               bus.wr_ack, bus.rd_ack, bus.rd_valid, bus.busy_write, bus.busy_read});
    end
    checks++;
    if (bus.app_addr !== '0 || bus.app_cmd !== 3'b000 || bus.app_wdf_data !== '0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr %h cmd %b wdata %h rdata %h want all zero",
               bus.app_addr, bus.app_cmd, bus.app_wdf_data, bus.rd_data);
    end
  endtask

  task automatic test_calib_gate();
    cpu_resetn = 1'b1;
    issue_write();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.wr_ack !== 1'b0 || bus.app_en !== 1'b0) begin
        errors++; $display("FAIL calib_hold cycle %0d got ack %b app_en %b want 0 0", i, bus.wr_ack, bus.app_en);
      end
    end
    bus.init_calib_complete = 1'b1;
    step();
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++; $display("FAIL calib_wr_ack got %b want 1", bus.wr_ack);
    end
    checks++;
    if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.busy_write} !== 4'b1111 || bus.app_cmd !== 3'b000) begin
      errors++;
      $display("FAIL calib_wr_state got en/wren/end/busy %b cmd %b want 1111 000",
               {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.busy_write}, bus.app_cmd);
    end
    step();
    checks++;
    if (bus.wr_ack !== 1'b0) begin
      errors++; $display("FAIL wr_ack_pulse got %b want 0", bus.wr_ack);
    end
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    for (int i = 0; i < 20 && bus.busy_write !== 1'b0; i++) step();
    checks++;
    if (bus.busy_write !== 1'b0) begin
      errors++; $display("FAIL calib_wr_done got busy_write %b want 0", bus.busy_write);
    end
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
  endtask

  task automatic test_write_handshake();
    logic [3:0] exp_bits;
    issue_write();
    step();
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++; $display("FAIL wr_hs_ack got %b want 1", bus.wr_ack);
    end
    for (int cyc = 1; cyc <= 6; cyc++) begin
      bus.app_rdy = (cyc == 2);
      bus.app_wdf_rdy = (cyc == 5);
      exp_bits = {(cyc <= 2), (cyc <= 5), (cyc <= 5), (cyc <= 5)};
      checks++;
      if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.busy_write} !== exp_bits) begin
        errors++;
        $display("FAIL wr_handshake cycle %0d got en/wren/end/busy %b want %b", cyc,
                 {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.busy_write}, exp_bits);
      end
      step();
    end
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
  endtask

  task automatic test_arbitration();
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    resp_allow = UNLIM;
    cmd_log.delete();
    wr_auto = 1'b1; rd_auto = 1'b1;
    issue_read();
    issue_write();
    for (int i = 0; i < 400 && cmd_log.size() < 27; i++) step();
    checks++;
    if (cmd_log.size() < 27) begin
      errors++; $display("FAIL arb_timeout got %0d commands want 27", cmd_log.size());
    end else begin
      for (int k = 0; k < 27; k++) begin
        checks++;
        if (cmd_log[k] !== (k % 9 != 8)) begin
          errors++; $display("FAIL arb_order idx %0d got rd=%0d want rd=%0d", k, cmd_log[k], (k % 9 != 8));
        end
      end
    end
    wr_auto = 1'b0; rd_auto = 1'b0;
    for (int i = 0; i < 200 && (bus.wr_req || bus.rd_req || bus.busy_read || bus.busy_write || exp_q.size() != 0); i++)
      step();
    checks++;
    if (bus.wr_req || bus.rd_req || bus.busy_read || exp_q.size() != 0) begin
      errors++; $display("FAIL arb_drain got wr_req %b rd_req %b busy_read %b want 0 0 0",
                         bus.wr_req, bus.rd_req, bus.busy_read);
    end
  endtask

  task automatic test_outstanding();
    int base;
    base = acc_rd;
    bus.app_rdy = 1'b1;
    resp_allow = resp_done;
    rd_auto = 1'b1;
    issue_read();
    repeat (30) step();
    checks++;
    if (acc_rd - base !== MAX_RD_OUT) begin
      errors++; $display("FAIL out_stall got %0d reads want %0d", acc_rd - base, MAX_RD_OUT);
    end
    checks++;
    if (bus.busy_read !== 1'b1) begin
      errors++; $display("FAIL out_busy_read got %b want 1", bus.busy_read);
    end
    resp_allow = resp_done + 1;
    repeat (30) step();
    checks++;
    if (acc_rd - base !== MAX_RD_OUT + 1) begin
      errors++; $display("FAIL out_one_more got %0d reads want %0d", acc_rd - base, MAX_RD_OUT + 1);
    end
    rd_auto = 1'b0;
    resp_allow = UNLIM;
    for (int i = 0; i < 200 && (bus.rd_req || bus.busy_read || exp_q.size() != 0); i++) step();
    checks++;
    if (bus.rd_req || bus.busy_read || exp_q.size() != 0) begin
      errors++; $display("FAIL out_drain got rd_req %b busy_read %b want 0 0", bus.rd_req, bus.busy_read);
    end
  endtask

  task automatic test_read_data();
    resp_fixed = 1'b1;
    resp_allow = resp_done;
    bus.app_rdy = 1'b1;
    issue_read();
    for (int i = 0; i < 20 && rd_q.size() != 0; i++) step();
    bus.app_rdy = 1'b0;
    issue_read();
    for (int i = 0; i < 20 && bus.rd_req; i++) step();
    step();
    checks++;
    if (bus.app_en !== 1'b1 || bus.app_cmd !== 3'b001) begin
      errors++; $display("FAIL rd_hold got en %b cmd %b want 1 001", bus.app_en, bus.app_cmd);
    end
    resp_allow = resp_done + 1;
    step();
    bus.app_rdy = 1'b1;
    step();
    bus.app_rdy = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== PATTERN) begin
      errors++; $display("FAIL rd_passthru got valid %b data %h want 1 %h", bus.rd_valid, bus.rd_data, PATTERN);
    end
    checks++;
    if (bus.busy_read !== 1'b1 || bus.app_en !== 1'b0) begin
      errors++; $display("FAIL rd_same_cycle got busy_read %b app_en %b want 1 0", bus.busy_read, bus.app_en);
    end
    resp_allow = resp_done + 1;
    step();
    step();
    checks++;
    if (bus.busy_read !== 1'b0) begin
      errors++; $display("FAIL rd_outstanding_zero got busy_read %b want 0", bus.busy_read);
    end
    step();
    resp_fixed = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    issue_write();
    for (int i = 0; i < 20 && bus.busy_write !== 1'b1; i++) step();
    checks++;
    if ({bus.busy_write, bus.app_en, bus.app_wdf_wren} !== 3'b111) begin
      errors++; $display("FAIL rst_mid_setup got busy/en/wren %b want 111", {bus.busy_write, bus.app_en, bus.app_wdf_wren});
    end
    bus.wr_req = 1'b0;
    cpu_resetn = 1'b0;
    #1;
    checks++;
    if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.busy_write, bus.wr_ack} !== 5'b00000) begin
      errors++; $display("FAIL rst_mid_async got en/wren/end/busy/ack %b want 00000",
                         {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.busy_write, bus.wr_ack});
    end
    wr_q.delete();
    step();
    step();
    cpu_resetn = 1'b1;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus.app_en !== 1'b0 || bus.wr_ack !== 1'b0 || bus.busy_write !== 1'b0) begin
        errors++; $display("FAIL rst_mid_idle cycle %0d got en %b ack %b busy %b want 0 0 0",
                           i, bus.app_en, bus.wr_ack, bus.busy_write);
      end
    end
    issue_write();
    step();
    checks++;
    if (bus.wr_ack !== 1'b1) begin
      errors++; $display("FAIL rst_new_write got ack %b want 1", bus.wr_ack);
    end
    for (int i = 0; i < 20 && bus.busy_write !== 1'b0; i++) step();
    step();
    checks++;
    if (bus.busy_write !== 1'b0 || wr_q.size() != 0) begin
      errors++; $display("FAIL rst_new_done got busy %b pending %0d want 0 0", bus.busy_write, wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_calib_gate();
    test_write_handshake();
    test_arbitration();
    test_outstanding();
    test_read_data();
    test_reset_mid();
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got wr %0d rd %0d data %0d want 0 0 0",
                         wr_q.size(), rd_q.size(), exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
